// File: rtl/cache_mem_arbiter.sv
// Shares one memory refill/writeback port between the icache and the dcache, one line transfer at a time.
// Optional macro ARB_ROUND_ROBIN_EN: alternate tie-breaks; when undefined the dcache wins every tie.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              icache2arb_req_i,
  input  logic              icache2arb_kill_i,
  input  logic [ADDR_W-1:0] icache2arb_addr_i,
  output logic              arb2icache_ack_o,
  output logic [LINE_W-1:0] arb2icache_data_o,
  input  logic              dcache2arb_req_i,
  input  logic              dcache2arb_we_i,
  input  logic [ADDR_W-1:0] dcache2arb_addr_i,
  input  logic [LINE_W-1:0] dcache2arb_wdata_i,
  output logic              arb2dcache_ack_o,
  output logic [LINE_W-1:0] arb2dcache_data_o,
  output logic              arb2mem_req_o,
  output logic              arb2mem_we_o,
  output logic [ADDR_W-1:0] arb2mem_addr_o,
  output logic [LINE_W-1:0] arb2mem_wdata_o,
  input  logic              mem2arb_ack_i,
  input  logic [LINE_W-1:0] mem2arb_data_i
);

  typedef enum logic [1:0] {IDLE, ICACHE_XFER, DCACHE_XFER, DRAIN} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              mem_we_reg;
  logic [LINE_W-1:0] mem_wdata_reg;
  logic              icache_ack_reg, icache_ack_next;
  logic              dcache_ack_reg, dcache_ack_next;
  logic [LINE_W-1:0] icache_data_reg, dcache_data_reg;
  logic              grant_i, grant_d;
  logic              icache_elig, dcache_elig, icache_drop, icache_wins_tie;

  assign icache_elig = icache2arb_req_i & ~icache2arb_kill_i;
  assign dcache_elig = dcache2arb_req_i;
  // Dropping the request mid-transfer is handled exactly like an explicit kill.
  assign icache_drop = icache2arb_kill_i | ~icache2arb_req_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_d_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_d_reg <= 1'b1;
    end else if (grant_i | grant_d) begin
      last_grant_d_reg <= grant_d;
    end
  end

  assign icache_wins_tie = last_grant_d_reg;
`else
  assign icache_wins_tie = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    grant_i         = 1'b0;
    grant_d         = 1'b0;
    icache_ack_next = 1'b0;
    dcache_ack_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (icache_elig && (!dcache_elig || icache_wins_tie)) begin
          grant_i    = 1'b1;
          state_next = ICACHE_XFER;
        end else if (dcache_elig) begin
          grant_d    = 1'b1;
          state_next = DCACHE_XFER;
        end
      end
      ICACHE_XFER: begin
        if (icache_drop) begin
          state_next = mem2arb_ack_i ? IDLE : DRAIN;
        end else if (mem2arb_ack_i) begin
          icache_ack_next = 1'b1;
          state_next      = IDLE;
        end
      end
      DCACHE_XFER: begin
        if (mem2arb_ack_i) begin
          dcache_ack_next = 1'b1;
          state_next      = IDLE;
        end
      end
      DRAIN: begin
        // Memory cannot abort; wait out the abandoned read and drop its data.
        if (mem2arb_ack_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= IDLE;
      mem_addr_reg    <= '0;
      mem_we_reg      <= 1'b0;
      mem_wdata_reg   <= '0;
      icache_ack_reg  <= 1'b0;
      dcache_ack_reg  <= 1'b0;
      icache_data_reg <= '0;
      dcache_data_reg <= '0;
    end else begin
      state_reg      <= state_next;
      icache_ack_reg <= icache_ack_next;
      dcache_ack_reg <= dcache_ack_next;
      if (grant_i) begin
        mem_addr_reg  <= icache2arb_addr_i;
        mem_we_reg    <= 1'b0;
        mem_wdata_reg <= '0;
      end else if (grant_d) begin
        mem_addr_reg  <= dcache2arb_addr_i;
        mem_we_reg    <= dcache2arb_we_i;
        mem_wdata_reg <= dcache2arb_wdata_i;
      end
      if (icache_ack_next) begin
        icache_data_reg <= mem2arb_data_i;
      end
      // Writebacks complete without touching the dcache read-data output.
      if (dcache_ack_next && !mem_we_reg) begin
        dcache_data_reg <= mem2arb_data_i;
      end
    end
  end

  assign arb2mem_req_o     = (state_reg != IDLE);
  assign arb2mem_we_o      = mem_we_reg;
  assign arb2mem_addr_o    = mem_addr_reg;
  assign arb2mem_wdata_o   = mem_wdata_reg;
  assign arb2icache_ack_o  = icache_ack_reg;
  assign arb2icache_data_o = icache_data_reg;
  assign arb2dcache_ack_o  = dcache_ack_reg;
  assign arb2dcache_data_o = dcache_data_reg;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus randomized rounds checked
// against a transaction-level model of grant order, memory operands and returned data.
module tb_cache_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          icache2arb_req_i, icache2arb_kill_i;
  logic [AW-1:0] icache2arb_addr_i;
  logic          arb2icache_ack_o;
  logic [LW-1:0] arb2icache_data_o;
  logic          dcache2arb_req_i, dcache2arb_we_i;
  logic [AW-1:0] dcache2arb_addr_i;
  logic [LW-1:0] dcache2arb_wdata_i;
  logic          arb2dcache_ack_o;
  logic [LW-1:0] arb2dcache_data_o;
  logic          arb2mem_req_o, arb2mem_we_o;
  logic [AW-1:0] arb2mem_addr_o;
  logic [LW-1:0] arb2mem_wdata_o;
  logic          mem2arb_ack_i;
  logic [LW-1:0] mem2arb_data_i;

  always #5 clk_i = ~clk_i;

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .icache2arb_req_i(icache2arb_req_i), .icache2arb_kill_i(icache2arb_kill_i),
    .icache2arb_addr_i(icache2arb_addr_i), .arb2icache_ack_o(arb2icache_ack_o),
    .arb2icache_data_o(arb2icache_data_o), .dcache2arb_req_i(dcache2arb_req_i),
    .dcache2arb_we_i(dcache2arb_we_i), .dcache2arb_addr_i(dcache2arb_addr_i),
    .dcache2arb_wdata_i(dcache2arb_wdata_i), .arb2dcache_ack_o(arb2dcache_ack_o),
    .arb2dcache_data_o(arb2dcache_data_o), .arb2mem_req_o(arb2mem_req_o),
    .arb2mem_we_o(arb2mem_we_o), .arb2mem_addr_o(arb2mem_addr_o),
    .arb2mem_wdata_o(arb2mem_wdata_o), .mem2arb_ack_i(mem2arb_ack_i),
    .mem2arb_data_i(mem2arb_data_i)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int i_ack_cnt = 0;
  int d_ack_cnt = 0;
  bit exp_last_d = 1'b1;          // model: last grant went to dcache
  logic [LW-1:0] exp_idata = '0;  // model: retained cache data outputs
  logic [LW-1:0] exp_ddata = '0;

  always @(posedge clk_i) begin
    if (arb2icache_ack_o === 1'b1) i_ack_cnt <= i_ack_cnt + 1;
    if (arb2dcache_ack_o === 1'b1) d_ack_cnt <= d_ack_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Tie-break rule from the arbitration policy.
  function automatic bit icache_wins_tie();
`ifdef ARB_ROUND_ROBIN_EN
    return exp_last_d;
`else
    return 1'b0;
`endif
  endfunction

  task automatic reset_dut();
    rst_i = 1'b1;
    icache2arb_req_i = 0; icache2arb_kill_i = 0; icache2arb_addr_i = '0;
    dcache2arb_req_i = 0; dcache2arb_we_i = 0; dcache2arb_addr_i = '0; dcache2arb_wdata_i = '0;
    mem2arb_ack_i = 0; mem2arb_data_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    exp_last_d = 1'b1; exp_idata = '0; exp_ddata = '0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (arb2mem_req_o === 1'b1) begin ok = 1; break; end
    end
  endtask

  // Memory responder: waits for a request, captures operands, acks after lat cycles.
  task automatic mem_serve(input int lat, input logic [LW-1:0] d, output logic [AW-1:0] a,
                           output logic w, output logic [LW-1:0] wd, output bit ok);
    a = '0; w = 0; wd = '0;
    wait_req(ok);
    if (!ok) return;
    a = arb2mem_addr_o; w = arb2mem_we_o; wd = arb2mem_wdata_o;
    repeat (lat) @(negedge clk_i);
    mem2arb_ack_i = 1'b1; mem2arb_data_i = d;
    @(negedge clk_i);
    mem2arb_ack_i = 1'b0; mem2arb_data_i = rnd_line();
  endtask

  task automatic test_reset();
    reset_dut();
    $display("test_reset: checking outputs after reset");
    n_cmp++;
    if ({arb2icache_ack_o, arb2dcache_ack_o, arb2mem_req_o, arb2mem_we_o} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000",
        {arb2icache_ack_o, arb2dcache_ack_o, arb2mem_req_o, arb2mem_we_o});
    end
    n_cmp++;
    if ({arb2icache_data_o, arb2dcache_data_o} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h %h want 0", arb2icache_data_o, arb2dcache_data_o);
    end
    n_cmp++;
    if ({arb2mem_addr_o, arb2mem_wdata_o} !== '0) begin
      n_fail++; $display("FAIL reset_mem: got %h %h want 0", arb2mem_addr_o, arb2mem_wdata_o);
    end
  endtask

  task automatic test_single_icache();
    logic [AW-1:0] a; logic w; logic [LW-1:0] wd, dat; bit ok; int i0, d0;
    dat = {4{32'hDEADBEEF}};
    i0 = i_ack_cnt; d0 = d_ack_cnt;
    icache2arb_addr_i = 32'h1000; icache2arb_req_i = 1'b1;
    mem_serve(2, dat, a, w, wd, ok);
    $display("test_single_icache: addr=%h we=%b ok=%0b", a, w, ok);
    n_cmp++;
    if (!ok || a !== 32'h1000 || w !== 1'b0) begin
      n_fail++; $display("FAIL single_mem: got ok=%0b addr=%h we=%b want addr=00001000 we=0", ok, a, w);
    end
    n_cmp++;
    if (arb2icache_ack_o !== 1'b1 || arb2icache_data_o !== dat) begin
      n_fail++; $display("FAIL single_ack: got ack=%b data=%h want 1 %h", arb2icache_ack_o, arb2icache_data_o, dat);
    end
    exp_idata = dat; exp_last_d = 1'b0;
    icache2arb_req_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (arb2icache_ack_o !== 1'b0 || arb2icache_data_o !== exp_idata) begin
      n_fail++; $display("FAIL single_pulse: got ack=%b data=%h want 0 %h", arb2icache_ack_o, arb2icache_data_o, exp_idata);
    end
    @(negedge clk_i);
    n_cmp++;
    if (i_ack_cnt - i0 !== 1 || d_ack_cnt - d0 !== 0) begin
      n_fail++; $display("FAIL single_counts: got i=%0d d=%0d want 1 0", i_ack_cnt - i0, d_ack_cnt - d0);
    end
  endtask

  task automatic test_tie();
    logic [AW-1:0] a; logic w; logic [LW-1:0] wd, rd, wd_d; bit ok, i_first, serve_i;
    reset_dut();
    wd_d = rnd_line();
    icache2arb_addr_i = 32'h2000; icache2arb_req_i = 1'b1;
    dcache2arb_addr_i = 32'h3000; dcache2arb_we_i = 1'b1; dcache2arb_wdata_i = wd_d; dcache2arb_req_i = 1'b1;
    i_first = icache_wins_tie();
    for (int k = 0; k < 2; k++) begin
      serve_i = (k == 0) ? i_first : !i_first;
      rd = rnd_line();
      if (k == 1) begin
        @(negedge clk_i);
        n_cmp++;
        if (arb2mem_req_o !== 1'b1) begin
          n_fail++; $display("FAIL tie_gap: got req=%b want 1 one cycle after ack", arb2mem_req_o);
        end
      end
      mem_serve(1, rd, a, w, wd, ok);
      $display("test_tie: k=%0d served %s addr=%h we=%b", k, serve_i ? "icache" : "dcache", a, w);
      n_cmp++;
      if (serve_i) begin
        if (!ok || a !== 32'h2000 || w !== 1'b0 || wd !== '0 || arb2icache_ack_o !== 1'b1 ||
            arb2icache_data_o !== rd || arb2dcache_ack_o !== 1'b0) begin
          n_fail++; $display("FAIL tie_icache: got addr=%h we=%b iack=%b dack=%b want 00002000 0 1 0",
            a, w, arb2icache_ack_o, arb2dcache_ack_o);
        end
        exp_idata = rd; exp_last_d = 1'b0; icache2arb_req_i = 1'b0;
      end else begin
        if (!ok || a !== 32'h3000 || w !== 1'b1 || wd !== wd_d || arb2dcache_ack_o !== 1'b1 ||
            arb2dcache_data_o !== exp_ddata || arb2icache_ack_o !== 1'b0) begin
          n_fail++; $display("FAIL tie_dcache: got addr=%h we=%b wd=%h dack=%b ddata=%h want 00003000 1 %h 1 %h",
            a, w, wd, arb2dcache_ack_o, arb2dcache_data_o, wd_d, exp_ddata);
        end
        exp_last_d = 1'b1; dcache2arb_req_i = 1'b0; dcache2arb_we_i = 1'b0;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic test_kill_drain();
    logic [AW-1:0] a; logic w; logic [LW-1:0] wd, rd; bit ok; int i0, d0;
    i0 = i_ack_cnt; d0 = d_ack_cnt;
    icache2arb_addr_i = 32'h4000; icache2arb_req_i = 1'b1;
    wait_req(ok);
    n_cmp++;
    if (!ok || arb2mem_addr_o !== 32'h4000) begin
      n_fail++; $display("FAIL kill_grant: got ok=%0b addr=%h want 00004000", ok, arb2mem_addr_o);
    end
    exp_last_d = 1'b0;
    dcache2arb_addr_i = 32'h5000; dcache2arb_we_i = 1'b0; dcache2arb_req_i = 1'b1;
    repeat (2) @(negedge clk_i);
    icache2arb_kill_i = 1'b1; icache2arb_req_i = 1'b0;
    @(negedge clk_i);
    icache2arb_kill_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (arb2mem_req_o !== 1'b1 || arb2mem_addr_o !== 32'h4000) begin
        n_fail++; $display("FAIL drain_hold c=%0d: got req=%b addr=%h want 1 00004000", c, arb2mem_req_o, arb2mem_addr_o);
      end
      icache2arb_kill_i = (c == 1);
      if (c == 3) begin mem2arb_ack_i = 1'b1; mem2arb_data_i = rnd_line(); end
      @(negedge clk_i);
    end
    mem2arb_ack_i = 1'b0; icache2arb_kill_i = 1'b0;
    $display("test_kill_drain: drained read at 00004000");
    n_cmp++;
    if (arb2icache_ack_o !== 1'b0 || arb2dcache_ack_o !== 1'b0 || arb2mem_req_o !== 1'b0 ||
        arb2icache_data_o !== exp_idata) begin
      n_fail++; $display("FAIL drain_end: got iack=%b dack=%b req=%b want 0 0 0",
        arb2icache_ack_o, arb2dcache_ack_o, arb2mem_req_o);
    end
    rd = rnd_line();
    mem_serve(0, rd, a, w, wd, ok);
    $display("test_kill_drain: dcache served addr=%h we=%b", a, w);
    n_cmp++;
    if (!ok || a !== 32'h5000 || w !== 1'b0 || arb2dcache_ack_o !== 1'b1 || arb2dcache_data_o !== rd) begin
      n_fail++; $display("FAIL drain_dcache: got addr=%h we=%b dack=%b data=%h want 00005000 0 1 %h",
        a, w, arb2dcache_ack_o, arb2dcache_data_o, rd);
    end
    exp_ddata = rd; exp_last_d = 1'b1; dcache2arb_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if (i_ack_cnt - i0 !== 0 || d_ack_cnt - d0 !== 1) begin
      n_fail++; $display("FAIL drain_counts: got i=%0d d=%0d want 0 1", i_ack_cnt - i0, d_ack_cnt - d0);
    end
  endtask

  task automatic test_kill_with_ack();
    bit ok; int i0;
    i0 = i_ack_cnt;
    icache2arb_addr_i = 32'h6000; icache2arb_req_i = 1'b1;
    wait_req(ok);
    exp_last_d = 1'b0;
    @(negedge clk_i);
    icache2arb_kill_i = 1'b1; mem2arb_ack_i = 1'b1; mem2arb_data_i = rnd_line();
    @(negedge clk_i);
    icache2arb_kill_i = 1'b0; icache2arb_req_i = 1'b0; mem2arb_ack_i = 1'b0;
    $display("test_kill_with_ack: kill and mem ack together at 00006000");
    n_cmp++;
    if (!ok || arb2icache_ack_o !== 1'b0 || arb2mem_req_o !== 1'b0 || arb2icache_data_o !== exp_idata) begin
      n_fail++; $display("FAIL kill_ack: got ok=%0b iack=%b req=%b data=%h want 1 0 0 %h",
        ok, arb2icache_ack_o, arb2mem_req_o, arb2icache_data_o, exp_idata);
    end
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if (i_ack_cnt - i0 !== 0 || arb2mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL kill_ack_idle: got iacks=%0d req=%b want 0 0", i_ack_cnt - i0, arb2mem_req_o);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int d0;
    d0 = d_ack_cnt;
    dcache2arb_addr_i = 32'h7000; dcache2arb_we_i = 1'b1; dcache2arb_wdata_i = rnd_line(); dcache2arb_req_i = 1'b1;
    wait_req(ok);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; dcache2arb_req_i = 1'b0; dcache2arb_we_i = 1'b0;
    exp_last_d = 1'b1; exp_idata = '0; exp_ddata = '0;
    $display("test_reset_mid: reset during dcache write");
    n_cmp++;
    if (!ok || {arb2icache_ack_o, arb2dcache_ack_o, arb2mem_req_o, arb2mem_we_o} !== 4'b0 ||
        {arb2icache_data_o, arb2dcache_data_o, arb2mem_addr_o, arb2mem_wdata_o} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got req=%b we=%b addr=%h want all 0",
        arb2mem_req_o, arb2mem_we_o, arb2mem_addr_o);
    end
    mem2arb_ack_i = 1'b1; mem2arb_data_i = rnd_line();
    @(negedge clk_i);
    mem2arb_ack_i = 1'b0;
    n_cmp++;
    if (arb2dcache_ack_o !== 1'b0 || arb2mem_req_o !== 1'b0 || arb2dcache_data_o !== '0) begin
      n_fail++; $display("FAIL reset_stray_ack: got dack=%b req=%b want 0 0", arb2dcache_ack_o, arb2mem_req_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (d_ack_cnt - d0 !== 0 || arb2mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: got dacks=%0d req=%b want 0 0", d_ack_cnt - d0, arb2mem_req_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a; logic w; logic [LW-1:0] wd, rd; bit ok, exp_i;
    icache2arb_addr_i = 32'h8000; icache2arb_req_i = 1'b1;
    dcache2arb_addr_i = 32'h9000; dcache2arb_we_i = 1'b0; dcache2arb_req_i = 1'b1;
    for (int r = 0; r < 4; r++) begin
      exp_i = icache_wins_tie();
      if (r > 0) begin
        @(negedge clk_i);
        n_cmp++;
        if (arb2mem_req_o !== 1'b1) begin
          n_fail++; $display("FAIL b2b_gap r=%0d: got req=%b want 1", r, arb2mem_req_o);
        end
      end
      rd = rnd_line();
      mem_serve(0, rd, a, w, wd, ok);
      $display("test_back_to_back: round %0d granted addr=%h (expected %s)", r, a, exp_i ? "icache" : "dcache");
      n_cmp++;
      if (exp_i) begin
        if (!ok || a !== 32'h8000 || arb2icache_ack_o !== 1'b1 || arb2icache_data_o !== rd || arb2dcache_ack_o !== 1'b0) begin
          n_fail++; $display("FAIL b2b_icache r=%0d: got addr=%h iack=%b dack=%b want 00008000 1 0",
            r, a, arb2icache_ack_o, arb2dcache_ack_o);
        end
        exp_idata = rd; exp_last_d = 1'b0;
      end else begin
        if (!ok || a !== 32'h9000 || arb2dcache_ack_o !== 1'b1 || arb2dcache_data_o !== rd || arb2icache_ack_o !== 1'b0) begin
          n_fail++; $display("FAIL b2b_dcache r=%0d: got addr=%h dack=%b iack=%b want 00009000 1 0",
            r, a, arb2dcache_ack_o, arb2icache_ack_o);
        end
        exp_ddata = rd; exp_last_d = 1'b1;
      end
    end
    icache2arb_req_i = 1'b0; dcache2arb_req_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_random();
    logic [AW-1:0] a, ia, da; logic w, dw; logic [LW-1:0] wd, rd, dwd, exp_data;
    bit ok, iq, dq, first_i, serve_i; int n, lat;
    for (int r = 0; r < 16; r++) begin
      iq = 1'($urandom_range(0, 1)); dq = 1'($urandom_range(0, 1));
      if (!iq && !dq) iq = 1'b1;
      ia = $urandom(); da = $urandom(); dw = 1'($urandom_range(0, 1)); dwd = rnd_line();
      icache2arb_addr_i = ia; icache2arb_req_i = iq;
      dcache2arb_addr_i = da; dcache2arb_we_i = dw; dcache2arb_wdata_i = dwd; dcache2arb_req_i = dq;
      n = int'(iq) + int'(dq);
      first_i = iq && (!dq || icache_wins_tie());
      for (int k = 0; k < n; k++) begin
        serve_i = (k == 0) ? first_i : !first_i;
        if (k == 1) begin
          @(negedge clk_i);
          n_cmp++;
          if (arb2mem_req_o !== 1'b1) begin
            n_fail++; $display("FAIL rand_gap r=%0d: got req=%b want 1", r, arb2mem_req_o);
          end
        end
        lat = $urandom_range(0, 4); rd = rnd_line();
        mem_serve(lat, rd, a, w, wd, ok);
        $display("test_random: r=%0d k=%0d %s addr=%h we=%b lat=%0d", r, k, serve_i ? "icache" : "dcache", a, w, lat);
        n_cmp++;
        if (serve_i) begin
          if (!ok || a !== ia || w !== 1'b0 || wd !== '0 || arb2icache_ack_o !== 1'b1 ||
              arb2icache_data_o !== rd || arb2dcache_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL rand_icache r=%0d: got addr=%h we=%b iack=%b dack=%b want %h 0 1 0",
              r, a, w, arb2icache_ack_o, arb2dcache_ack_o, ia);
          end
          exp_idata = rd; exp_last_d = 1'b0; icache2arb_req_i = 1'b0;
        end else begin
          exp_data = dw ? exp_ddata : rd;
          if (!ok || a !== da || w !== dw || wd !== dwd || arb2dcache_ack_o !== 1'b1 ||
              arb2dcache_data_o !== exp_data || arb2icache_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL rand_dcache r=%0d: got addr=%h we=%b dack=%b data=%h want %h %b 1 %h",
              r, a, w, arb2dcache_ack_o, arb2dcache_data_o, da, dw, exp_data);
          end
          exp_ddata = exp_data; exp_last_d = 1'b1; dcache2arb_req_i = 1'b0;
        end
      end
      @(negedge clk_i);
    end
  endtask

  initial begin
    test_reset();
    test_single_icache();
    test_tie();
    test_kill_drain();
    test_kill_with_ack();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single main-memory refill/writeback port between the instruction cache and the data cache. It accepts line-read requests from the icache controller and line-read/line-write requests from the dcache controller, grants one at a time, and holds the memory request stable until the memory acknowledges. It returns the response to the granted cache and absorbs icache kills without corrupting the memory transaction. It sits between both cache controllers and the memory/bus interface.

## Interface
Parameters:
- ADDR_W, 32, line address width
- LINE_W, 128, cache line width in bits

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset; synchronous, active-high
- icache2arb_req_i  in  1  icache line-read request, level
- icache2arb_kill_i  in  1  icache abandons its current or pending request
- icache2arb_addr_i  in  ADDR_W  icache line address
- arb2icache_ack_o  out  1  one-cycle pulse; read data valid
- arb2icache_data_o  out  LINE_W  line read for icache
- dcache2arb_req_i  in  1  dcache request, level
- dcache2arb_we_i  in  1  1 = line write (writeback), 0 = line read
- dcache2arb_addr_i  in  ADDR_W  dcache line address
- dcache2arb_wdata_i  in  LINE_W  writeback data
- arb2dcache_ack_o  out  1  one-cycle pulse; write done or read data valid
- arb2dcache_data_o  out  LINE_W  line read for dcache
- arb2mem_req_o  out  1  memory request, held until mem2arb_ack_i
- arb2mem_we_o  out  1  memory write enable
- arb2mem_addr_o  out  ADDR_W  memory address
- arb2mem_wdata_o  out  LINE_W  memory write data
- mem2arb_ack_i  in  1  one-cycle memory completion pulse
- mem2arb_data_i  in  LINE_W  memory read data, valid with ack

## Operation
- States: IDLE, ICACHE_XFER, DCACHE_XFER, DRAIN.
- IDLE:
  - Icache is eligible when icache2arb_req_i & ~icache2arb_kill_i; dcache is eligible when dcache2arb_req_i.
  - If exactly one requester is eligible, grant it.
  - If both are eligible, the tie is broken per Configuration.
  - On grant, register addr, we, and wdata into the memory-side registers (icache: we=0, wdata=0) and enter the matching XFER state.
- XFER:
  - arb2mem_req_o=1; address, we, and wdata come from registers and stay constant.
  - On mem2arb_ack_i, register mem2arb_data_i into the granted cache's data output, pulse that cache's ack next cycle, and go to IDLE.
- Kill in ICACHE_XFER:
  - Kill with no mem ack in the same cycle goes to DRAIN.
  - Kill in the same cycle as mem ack discards the data, produces no ack, and goes to IDLE.
- DRAIN:
  - arb2mem_req_o stays 1, since memory cannot abort.
  - On mem2arb_ack_i, discard the data, produce no ack, and go to IDLE.
  - Kills arriving in DRAIN are ignored.
- Icache deasserting icache2arb_req_i without kill during ICACHE_XFER is treated as kill.
- Dcache must hold its request and operands until arb2dcache_ack_o. Dcache has no kill.
- The data outputs retain their last value between acks. Writes leave arb2dcache_data_o unchanged.
- Reset (any state, including mid-transaction):
  - Go to IDLE; clear all outputs to 0 and clear the memory-side registers.
  - Any in-flight memory ack arriving after reset is ignored in IDLE.

## Timing
- Grant latency: req in IDLE at cycle N → arb2mem_req_o=1 at cycle N+1.
- Completion: mem2arb_ack_i at cycle M → cache ack pulse and data valid at cycle M+1, arbiter in IDLE at M+1.
- A new grant is possible at M+1 (arb2mem_req_o=1 at M+2). Minimum gap between memory requests is one cycle.
- Ack outputs are registered and exactly one cycle wide.
- Every output is 0 after reset.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - A 1-bit last-grant register drives tie-breaks; on a tie, grant the requester not granted last.
  - The register resets to "dcache", so icache wins the first tie.
  - The register updates only on grant.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, dcache wins every tie, and no last-grant register exists.

## Test plan
- Single icache read, addr 0x1000, mem ack 3 cycles after req → arb2mem_addr_o=0x1000, we=0; arb2icache_ack_o pulses once with mem data 0xDEADBEEF_...; dcache ack stays 0.
- Simultaneous icache 0x2000 and dcache write 0x3000 → with ARB_ROUND_ROBIN_EN: icache is served first, then dcache. Without it: dcache write (we=1, wdata passed through) is served first. The second transaction starts one cycle after the first ack.
- Icache kill two cycles into a transfer, mem ack four cycles later → arbiter drains, arb2mem_req_o stays high until ack, no icache ack, pending dcache request is granted afterwards.
- Kill in the same cycle as mem ack → no icache ack, arbiter returns to IDLE next cycle.
- rst_i asserted during DCACHE_XFER, then a stray mem ack → all outputs 0, no dcache ack, arbiter remains IDLE.
- Back-to-back ties under ARB_ROUND_ROBIN_EN (4 rounds) → grants alternate icache, dcache, icache, dcache.
